abs_unit: RTL and testbench
===========================

ABS_UNIT -- requirements
Module: abs_unit

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, width of the input sample and of the magnitude output.
REQ-002 The block SHALL have one parameter: ACC_W, default 16, width of the running-sum output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  substract is valid this cycle.
REQ-006 substract  input  DATA_W  two's-complement difference sample.
REQ-007 acc_clr  input  1  clear running sum.
REQ-008 out_valid  output  1  abs/neg are valid this cycle.
REQ-009 abs  output  DATA_W  magnitude of the accepted sample, unsigned.
REQ-010 neg  output  1  accepted sample was negative.
REQ-011 sum  output  ACC_W  running sum of accepted magnitudes, unsigned.
REQ-012 sat  output  1  present only when ABS_SAT_EN is defined; the current abs was clipped.

Function
REQ-013 On a cycle with in_valid=1, the block SHALL register abs=|substract|, neg=substract[DATA_W-1] and out_valid=1, visible after that edge (latency 1 cycle).
REQ-014 On a cycle with in_valid=0, out_valid SHALL be 0 after the edge; abs and neg SHALL hold their last values.
REQ-015 Non-negative input SHALL pass unchanged; negative input SHALL be negated in two's complement (e.g. 25->25, -25 (0xE7)->25, 0->0, -1->1).
REQ-016 Most-negative input (0x80 at DATA_W=8) SHALL yield 0x80, i.e. unsigned 128, when ABS_SAT_EN is undefined.
REQ-017 sum SHALL add the new abs, zero-extended to ACC_W, on every in_valid=1 cycle; it updates on the same edge as abs.
REQ-018 sum SHALL saturate at 2^ACC_W-1 and SHALL NOT wrap.
REQ-019 acc_clr=1 SHALL set sum to 0 on the next edge; if in_valid=1 on the same cycle, sum SHALL equal that sample's magnitude (clear, then add).
REQ-020 The block SHALL accept one sample per cycle with no back-pressure and no stall.

Reset
REQ-021 When rst=1 at a rising edge, out_valid, abs, neg, sum and sat SHALL become 0; rst SHALL take priority over in_valid and acc_clr.
REQ-022 If rst is asserted mid-stream, the in-flight sample SHALL be discarded; the first sample after reset release SHALL appear one cycle later.

Configuration
REQ-023 Macro ABS_SAT_EN defined: the most-negative input SHALL produce abs=2^(DATA_W-1)-1 (127 at DATA_W=8) with sat=1, keeping abs a valid positive signed value; every other input SHALL give sat=0.
REQ-024 Macro ABS_SAT_EN undefined: the sat port SHALL be absent, and behaviour SHALL follow REQ-016.

Structure
REQ-025 DATA_W/ACC_W default constants and the saturation limit helper SHALL live in a shared package, abs_pkg.
REQ-026 The combinational magnitude logic SHALL be one sub-module, abs_core (substract -> magnitude, neg, sat); the registers and accumulator SHALL live in abs_unit.

Verification
REQ-027 rst=1 for 2 cycles -> out_valid=0, abs=0, sum=0.
REQ-028 in_valid pulse with 25, then -25 -> abs=25, neg=0, then abs=25, neg=1; sum=50.
REQ-029 Input 0x80 -> abs=0x80, neg=1 without the macro; abs=0x7F, sat=1 with ABS_SAT_EN.
REQ-030 Inputs 0 and -1 -> abs=0 then 1; in_valid=0 gap -> out_valid=0, abs holds 1.
REQ-031 Stream 600 samples of -128 without the macro -> sum saturates at 65535 and does not wrap.
REQ-032 acc_clr with in_valid=1 and input -7 -> sum=7; rst asserted mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/abs_pkg.sv
// Shared constants and helpers for the absolute-value / accumulate unit.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: default DATA_W/ACC_W and the positive saturation limit helper
// used when ABS_SAT_EN clips the most-negative input.
package abs_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  // Largest positive two's-complement value representable in w bits.
  function automatic int sat_limit(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/abs_unit_if.sv
// Sample/result bundle between a producer and abs_unit.
// Latency: n/a (wiring only).
// Backpressure: none; a sample is taken on every in_valid cycle.
//
// Signals: in_valid, substract[DATA_W], acc_clr (master -> slave);
//          out_valid, abs[DATA_W], neg, sum[ACC_W], sat (slave -> master).
// sat exists only when the macro ABS_SAT_EN is defined.
interface abs_unit_if
  import abs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] substract;
  logic              acc_clr;
  logic              out_valid;
  logic [DATA_W-1:0] abs;
  logic              neg;
  logic [ACC_W-1:0]  sum;
`ifdef ABS_SAT_EN
  logic              sat;
`endif

  modport master (
    output in_valid, substract, acc_clr,
`ifdef ABS_SAT_EN
    input  sat,
`endif
    input  out_valid, abs, neg, sum
  );

  modport slave (
    input  in_valid, substract, acc_clr,
`ifdef ABS_SAT_EN
    output sat,
`endif
    output out_valid, abs, neg, sum
  );

endinterface

// File: rtl/abs_core.sv
// Combinational two's-complement magnitude of one sample.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: substract_i[DATA_W] -> mag_o[DATA_W], neg_o, sat_o (ABS_SAT_EN only).
// Without ABS_SAT_EN the most-negative input maps onto itself, which read
// as unsigned is exactly its magnitude; with it, that input is clipped.
module abs_core
  import abs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] substract_i,
  output logic [DATA_W-1:0] mag_o,
`ifdef ABS_SAT_EN
  output logic              sat_o,
`endif
  output logic              neg_o
);

  assign neg_o = substract_i[DATA_W-1];

`ifdef ABS_SAT_EN
  localparam logic [DATA_W-1:0] SatLim = DATA_W'(sat_limit(DATA_W));

  // Only the most-negative value has no positive counterpart.
  logic is_min;
  assign is_min = neg_o && (substract_i[DATA_W-2:0] == '0);
  assign sat_o  = is_min;
  assign mag_o  = is_min ? SatLim : (neg_o ? (~substract_i + 1'b1) : substract_i);
`else
  assign mag_o  = neg_o ? (~substract_i + 1'b1) : substract_i;
`endif

endmodule

// File: rtl/abs_unit.sv
// Registered magnitude of each accepted sample plus a saturating running sum.
// Latency: 1 cycle from in_valid to out_valid/abs/neg/sum.
// Backpressure: none; one sample accepted every cycle, never stalls.
//
// Ports: clk, rst (sync, active-high), bus (abs_unit_if.slave).
// Optional macro ABS_SAT_EN: clip the most-negative input and drive bus.sat.
module abs_unit
  import abs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input logic       clk,
  input logic       rst,
  abs_unit_if.slave bus
);

  logic [DATA_W-1:0] mag;
  logic              mag_neg;
`ifdef ABS_SAT_EN
  logic              mag_sat;
  logic              sat_q, sat_d;
`endif

  abs_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .substract_i(bus.substract),
    .mag_o      (mag),
`ifdef ABS_SAT_EN
    .sat_o      (mag_sat),
`endif
    .neg_o      (mag_neg)
  );

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] abs_q, abs_d;
  logic              neg_q, neg_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [ACC_W-1:0]  sum_base;
  logic [ACC_W:0]    sum_ext;

  always_comb begin
    out_valid_d = bus.in_valid;
    abs_d       = abs_q;
    neg_d       = neg_q;
`ifdef ABS_SAT_EN
    sat_d       = sat_q;
`endif
    // Clear happens before the add so a same-cycle sample starts a fresh sum.
    sum_base    = bus.acc_clr ? '0 : sum_q;
    sum_ext     = {1'b0, sum_base};
    sum_d       = sum_base;
    if (bus.in_valid) begin
      abs_d   = mag;
      neg_d   = mag_neg;
`ifdef ABS_SAT_EN
      sat_d   = mag_sat;
`endif
      // Extra top bit catches overflow; clamp to all-ones instead of wrapping.
      sum_ext = {1'b0, sum_base} + {1'b0, ACC_W'(mag)};
      sum_d   = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      abs_q       <= '0;
      neg_q       <= 1'b0;
      sum_q       <= '0;
`ifdef ABS_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      abs_q       <= abs_d;
      neg_q       <= neg_d;
      sum_q       <= sum_d;
`ifdef ABS_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.abs       = abs_q;
  assign bus.neg       = neg_q;
  assign bus.sum       = sum_q;
`ifdef ABS_SAT_EN
  assign bus.sat       = sat_q;
`endif

endmodule

// File: tb/tb_abs_unit.sv
// Self-checking bench for abs_unit: directed cases plus randomized stream
// compared every cycle against an integer-arithmetic reference model.
module tb_abs_unit;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int MAG_CLIP = (1 << (DW - 1)) - 1;
  localparam int SUM_MAX  = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  abs_unit_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

  abs_unit #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after each rising edge, from plain integer rules.
  bit model_ok = 0;
  int m_vld = 0, m_abs = 0, m_neg = 0, m_sum = 0, m_sat = 0;

  initial forever begin
    int v;
    int mag;
    @(posedge clk);
    if (rst === 1'b1) begin
      m_vld = 0; m_abs = 0; m_neg = 0; m_sum = 0; m_sat = 0;
      model_ok = 1;
    end else begin
      if (bus.acc_clr) m_sum = 0;
      if (bus.in_valid) begin
        v     = int'($signed(bus.substract));
        m_neg = (v < 0) ? 1 : 0;
        mag   = (v < 0) ? -v : v;
        m_sat = 0;
`ifdef ABS_SAT_EN
        if (mag > MAG_CLIP) begin
          mag   = MAG_CLIP;
          m_sat = 1;
        end
`endif
        m_abs = mag;
        m_sum = m_sum + mag;
        if (m_sum > SUM_MAX) m_sum = SUM_MAX;
        m_vld = 1;
      end else begin
        m_vld = 0;
      end
    end
  end

  // Per-cycle comparison on the falling edge, once the model has seen a reset.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("mdl_out_valid", 32'(bus.out_valid), 32'(m_vld));
      check("mdl_abs", 32'(bus.abs), 32'(m_abs));
      check("mdl_neg", 32'(bus.neg), 32'(m_neg));
      check("mdl_sum", 32'(bus.sum), 32'(m_sum));
`ifdef ABS_SAT_EN
      check("mdl_sat", 32'(bus.sat), 32'(m_sat));
`endif
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic apply(input logic r, input logic v, input logic [DW-1:0] d, input logic c);
    rst           = r;
    bus.in_valid  = v;
    bus.substract = d;
    bus.acc_clr   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.substract = '0;
    bus.acc_clr   = 1'b0;

    // Reset held for two cycles.
    apply(1'b1, 1'b0, 8'h00, 1'b0);
    apply(1'b1, 1'b1, 8'h33, 1'b1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_abs", 32'(bus.abs), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);

    // 25 then -25.
    apply(1'b0, 1'b1, 8'd25, 1'b0);
    check("p25_valid", 32'(bus.out_valid), 32'd1);
    check("p25_abs", 32'(bus.abs), 32'd25);
    check("p25_neg", 32'(bus.neg), 32'd0);
    apply(1'b0, 1'b1, 8'hE7, 1'b0);
    check("m25_abs", 32'(bus.abs), 32'd25);
    check("m25_neg", 32'(bus.neg), 32'd1);
    check("m25_sum", 32'(bus.sum), 32'd50);

    // Most-negative input.
    apply(1'b0, 1'b1, 8'h80, 1'b0);
    check("min_neg", 32'(bus.neg), 32'd1);
`ifdef ABS_SAT_EN
    check("min_abs", 32'(bus.abs), 32'h7F);
    check("min_sat", 32'(bus.sat), 32'd1);
    check("min_sum", 32'(bus.sum), 32'd177);
`else
    check("min_abs", 32'(bus.abs), 32'h80);
    check("min_sum", 32'(bus.sum), 32'd178);
`endif

    // 0, -1, then an idle gap.
    apply(1'b0, 1'b1, 8'h00, 1'b0);
    check("zero_abs", 32'(bus.abs), 32'd0);
    check("zero_neg", 32'(bus.neg), 32'd0);
    apply(1'b0, 1'b1, 8'hFF, 1'b0);
    check("m1_abs", 32'(bus.abs), 32'd1);
`ifdef ABS_SAT_EN
    check("m1_sat", 32'(bus.sat), 32'd0);
`endif
    apply(1'b0, 1'b0, 8'h55, 1'b0);
    check("gap_valid", 32'(bus.out_valid), 32'd0);
    check("gap_abs_hold", 32'(bus.abs), 32'd1);
    check("gap_neg_hold", 32'(bus.neg), 32'd1);

    // Clear together with a sample: clear then add.
    apply(1'b0, 1'b1, 8'hF9, 1'b1);
    check("clr_add_sum", 32'(bus.sum), 32'd7);
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_only_sum", 32'(bus.sum), 32'd0);

    // Long stream of most-negative samples: sum pins at the top, no wrap.
    for (int i = 0; i < 600; i++) apply(1'b0, 1'b1, 8'h80, 1'b0);
    check("sat_sum", 32'(bus.sum), 32'd65535);
    apply(1'b0, 1'b1, 8'h01, 1'b0);
    check("sat_sum_hold", 32'(bus.sum), 32'd65535);

    // Randomized stream with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] d;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       d = 8'h80;
        1:       d = 8'h7F;
        2:       d = 8'h00;
        3:       d = 8'hFF;
        default: d = DW'($urandom);
      endcase
      apply($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7, d,
            $urandom_range(0, 99) == 0);
    end

    // Reset in the middle of a stream.
    apply(1'b0, 1'b1, 8'd33, 1'b0);
    apply(1'b1, 1'b1, 8'd44, 1'b1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_abs", 32'(bus.abs), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    apply(1'b0, 1'b1, 8'hF6, 1'b0);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_abs", 32'(bus.abs), 32'd10);
    check("post_rst_sum", 32'(bus.sum), 32'd10);
    apply(1'b0, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
